// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/sub computed nibble-serially on one shared 4-bit ripple slice.
module nibble_serial_adder_fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             c_nib, last;
  assign a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib = b_q[{idx_q, 2'b00} +: 4];
  assign last  = idx_q == IW'(NIB - 1);
  nibble_serial_adder_fa4 u_fa4 (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_q),
    .s   (s_nib),
    .cout(c_nib)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = op_sub ? ~b : b;
      carry_d = op_sub | cin;
      idx_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      sum_d[{idx_q, 2'b00} +: 4] = s_nib;
      carry_d = c_nib;
      idx_d   = idx_q + IW'(1);
      cout_d  = last ? c_nib : cout_q;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end
  assign in_ready  = rst_n && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized and directed checks against an arithmetic reference model.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op_sub, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;
  int          vec = 0;
  int          err = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    int unsigned r;
    r = s ? (32'(x) + 32'h10000 - 32'(y)) : (32'(x) + 32'(y) + 32'(c));
    return s ? {x >= y, r[15:0]} : r[16:0];
  endfunction

  task automatic do_op(input string name, input logic [15:0] aa, input logic [15:0] bb,
                       input logic ci, input logic sb, input int hold, input logic poke);
    logic [16:0] exp;
    int n;
    exp = model(aa, bb, ci, sb);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vec++;
    if (in_ready !== 1'b1) begin err++; $display("FAIL %s in_ready got %b want 1", name, in_ready); end
    a = aa; b = bb; cin = ci; op_sub = sb; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vec++;
    if (n != 5) begin err++; $display("FAIL %s latency got %0d want 5", name, n); end
    vec++;
    if ({cout, sum} !== exp) begin err++; $display("FAIL %s result got cout=%b sum=%h want cout=%b sum=%h", name, cout, sum, exp[16], exp[15:0]); end
    for (int i = 0; i < hold; i++) begin
      if (poke) begin in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); end
      @(negedge clk);
      vec++;
      if ({out_valid, busy, in_ready, cout, sum} !== {3'b110, exp}) begin
        err++;
        $display("FAIL %s hold%0d got v=%b busy=%b rdy=%b cout=%b sum=%h want v=1 busy=1 rdy=0 cout=%b sum=%h",
                 name, i, out_valid, busy, in_ready, cout, sum, exp[16], exp[15:0]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    vec++;
    if ({out_valid, in_ready} !== 2'b01) begin err++; $display("FAIL %s release got v=%b rdy=%b want v=0 rdy=1", name, out_valid, in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; op_sub = 1'b0; cin = 1'b1; a = 16'h1111; b = 16'h2222;
    repeat (3) @(negedge clk);
    vec++;
    if ({out_valid, busy, in_ready, cout, sum} !== 20'h0) begin
      err++; $display("FAIL reset got v=%b busy=%b rdy=%b cout=%b sum=%h want all 0", out_valid, busy, in_ready, cout, sum);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    vec++;
    if ({in_ready, busy} !== 2'b10) begin err++; $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy); end
    repeat (2) @(negedge clk);
    vec++;
    if ({busy, out_valid} !== 2'b00) begin err++; $display("FAIL reset_idle got busy=%b v=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_add();
    do_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    do_op("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1'b0);
    do_op("ripple_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    do_op("ripple_0fff", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_sub();
    do_op("sub_1000", 16'h1000, 16'h0001, 1'b1, 1'b1, 0, 1'b0);
    do_op("sub_0000", 16'h0000, 16'h0001, 1'b1, 1'b1, 0, 1'b0);
    do_op("sub_8000", 16'h8000, 16'h8000, 1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op("backpressure", 16'hBEEF, 16'h1357, 1'b1, 1'b0, 10, 1'b1);
    do_op("b2b", 16'h7FFF, 16'h8001, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_abort();
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vec++;
    if ({out_valid, busy, in_ready, cout, sum} !== 20'h0) begin
      err++; $display("FAIL abort_run got v=%b busy=%b rdy=%b cout=%b sum=%h want all 0", out_valid, busy, in_ready, cout, sum);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec++;
      if ({out_valid, busy} !== 2'b00) begin err++; $display("FAIL abort_quiet%0d got v=%b busy=%b want 0 0", i, out_valid, busy); end
    end
    do_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    vec++;
    if ({out_valid, busy, cout, sum} !== 19'h0) begin
      err++; $display("FAIL abort_done got v=%b busy=%b cout=%b sum=%h want all 0", out_valid, busy, cout, sum);
    end
    do_op("after_abort_done", 16'hFFF0, 16'h0020, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_op("random", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequencer that computes WIDTH-bit add/subtract by driving one shared 4-bit ripple-carry adder slice (full-adder chain, 4-bit a/b, cin, 4-bit s, carry) over successive nibbles, least-significant first, with a registered carry between nibbles. It sits between a requester using a valid/ready handshake and the existing 4-bit parallel adder datapath. That adder is instantiated inside this block and is not duplicated. It trades latency for area on wide operands.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥4; NIB = WIDTH/4
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept; high only in IDLE
- op_sub  input  1  0 = a+b+cin, 1 = a−b (cin ignored)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  add: carry-out; sub: 1 = no borrow (a ≥ b unsigned)
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready: latch a, b into operand registers. If op_sub, latch b inverted.
  - Carry register loads cin (add) or 1 (sub). Nibble index loads 0. Go to RUN.
- RUN
  - Each cycle, the adder slice takes A[4i+3:4i], B'[4i+3:4i] and the carry register.
  - Its s is written into sum[4i+3:4i]. The carry register takes the adder carry. i increments.
  - When i = NIB−1 completes, go to DONE. cout is the final carry.
- DONE
  - out_valid=1. sum/cout stay stable until out_valid&out_ready, then go to IDLE.
- Operands are captured at accept. Later changes on a/b/cin/op_sub have no effect until the next accept.
- in_valid is ignored outside IDLE and while rst_n=0.
- Arithmetic is modulo 2^WIDTH. No overflow flag. Signed interpretation is left to the consumer.
- Sum nibbles not yet computed hold their prior value. sum is only defined while out_valid=1.

## Timing
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE. out_valid=0, busy=0, sum=0, cout=0, carry register=0, index=0.
  - in_ready=0 while rst_n=0. in_ready=1 from the first cycle after release.
- Accept in cycle 0 (handshake at the edge ending cycle 0).
  - RUN occupies cycles 1..NIB. out_valid=1 from cycle NIB+1.
  - WIDTH=16 gives accept→out_valid of 5 cycles.
- Result handshake in cycle k gives in_ready=1 in cycle k+1.
  - No accept/result overlap. Minimum throughput is one op per NIB+2 cycles.
- out_ready held high ahead of time: DONE lasts exactly 1 cycle.
- Backpressure: DONE is held indefinitely. Outputs are bit-stable and busy=1.
- Reset mid-RUN or in DONE: the operation is aborted and no out_valid is produced. The next accept computes correctly.
- WIDTH=4: a single RUN cycle, with latency 2.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1. Required: out_valid=0, busy=0, sum=0, cout=0, in_ready=0. After release, in_ready=1 and no op is started until an in_valid edge occurs in IDLE.
- Add: a=0x1234, b=0x4321, cin=0, op_sub=0. Required: out_valid in cycle 5, sum=0x5555, cout=0. With cin=1: sum=0x5556.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0. Required: sum=0x0000, cout=1. Also a=0x0FFF, b=0x0000, cin=1. Required: sum=0x1000, cout=0.
- Subtract (cin=1 during both ops, which must be ignored):
  - 0x1000−0x0001. Required: sum=0x0FFF, cout=1.
  - 0x0000−0x0001. Required: sum=0xFFFF, cout=0.
  - 0x8000−0x8000. Required: sum=0x0000, cout=1.
- Handshake/backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid. Required: sum/cout stable, in_ready=0.
  - Drive a different in_valid request during this time. Required: not accepted, and a/b changes after accept do not alter the result.
  - Then set out_ready=1. Required: in_ready=1 next cycle, and a back-to-back op completes correctly.
- Abort: pull rst_n low in cycle 2 of RUN. Required: no out_valid, outputs reset. The following op 0x00FF+0x0001 gives 0x0100, cout=0.
